instr_mem_loader: RTL and testbench

Loadable, parametrised instruction memory for the x9 core. It replaces a fixed, combinationally read ROM with three things: a synchronous-read fetch port with stall support, a valid/ready program-load port, and a small load state machine. The fetch stage reads instructions through it. A test harness or boot controller streams a program into it before the core is released.

---
 rtl/x9_imem_pkg.sv | 18 +
 rtl/instr_mem_loader_imem_array.sv | 29 ++
 rtl/instr_mem_loader.sv | 116 +++++++++++
 tb/tb_instr_mem_loader.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/x9_imem_pkg.sv
// x9 instruction memory shared definitions.
//   imem_state_t   : load state machine encoding (IDLE / LOAD / DONE)
//   X9_A_DEFAULT   : default address width (depth = 2**A words)
//   X9_W_DEFAULT   : default instruction width
//   X9_NOP_DEFAULT : default word presented while fetch is blocked
package x9_imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } imem_state_t;

  localparam int unsigned X9_A_DEFAULT = 4;
  localparam int unsigned X9_W_DEFAULT = 9;
  localparam logic [X9_W_DEFAULT-1:0] X9_NOP_DEFAULT = '0;

endpackage

// File: rtl/instr_mem_loader_imem_array.sv
// imem_array: 2**A x W storage, no reset on contents.
//   clk_i            : clock
//   we_i/waddr_i/wdata_i : synchronous write port
//   re_i/raddr_i     : synchronous read request; rdata_o holds when re_i = 0
//   rdata_o          : registered read data
module imem_array #(
  parameter int A = 4,
  parameter int W = 9
) (
  input  logic         clk_i,
  input  logic         we_i,
  input  logic [A-1:0] waddr_i,
  input  logic [W-1:0] wdata_i,
  input  logic         re_i,
  input  logic [A-1:0] raddr_i,
  output logic [W-1:0] rdata_o
);

  logic [W-1:0] mem_q [2**A];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: loadable instruction memory for the x9 core.
//   clk_i, reset_i       : clock, synchronous active-high reset
//   load_start_i/len_i   : begin a program load of load_len_i words (1..2**A)
//   load_valid_i/data_i  : program word stream; load_ready_o accepts it
//   load_done_o          : one-cycle pulse after the last word is written
//   load_err_o           : one-cycle pulse for an illegal load length
//   busy_o               : state machine not in IDLE
//   fetch_en_i/addr_i    : fetch request (low = stall)
//   instr_out_o/valid_o  : fetched word, one cycle after the request
module instr_mem_loader
  import x9_imem_pkg::*;
#(
  parameter int          A   = X9_A_DEFAULT,
  parameter int          W   = X9_W_DEFAULT,
  parameter logic [W-1:0] NOP = {W{1'b0}}
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load_start_i,
  input  logic [A:0]   load_len_i,
  input  logic         load_valid_i,
  input  logic [W-1:0] load_data_i,
  output logic         load_ready_o,
  output logic         load_done_o,
  output logic         load_err_o,
  output logic         busy_o,
  input  logic         fetch_en_i,
  input  logic [A-1:0] fetch_addr_i,
  output logic [W-1:0] instr_out_o,
  output logic         instr_valid_o
);

  localparam int         DEPTH   = 2**A;
  localparam logic [A:0] LEN_MAX = (A+1)'(DEPTH);

  imem_state_t  state_q;
  logic [A-1:0] wr_ptr_q;
  logic [A:0]   count_q;
  logic         done_q, err_q;
  logic         valid_q, nop_q;
  logic [W-1:0] rdata;

  logic accept, len_ok, we, re;

  assign accept = (state_q == LOAD) && load_valid_i;
  assign len_ok = (load_len_i != '0) && (load_len_i <= LEN_MAX);
  // Reset wins over a same-cycle handshake so an aborted load stops at once.
  assign we     = accept && !reset_i;
  // Reads only in IDLE: a fetch can never collide with a program write.
  assign re     = fetch_en_i && (state_q == IDLE) && !reset_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: if (load_start_i) begin
          if (len_ok) begin
            state_q  <= LOAD;
            wr_ptr_q <= '0;
            count_q  <= load_len_i;
          end else begin
            err_q <= 1'b1;
          end
        end
        LOAD: if (accept) begin
          // wr_ptr wraps on a full-depth load; count decides termination.
          wr_ptr_q <= wr_ptr_q + A'(1);
          count_q  <= count_q - (A+1)'(1);
          if (count_q == (A+1)'(1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Fetch side: nop_q selects the NOP word instead of the array read
  // register, so instr_out comes straight from flops either way.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      nop_q   <= 1'b1;
      valid_q <= 1'b0;
    end else if (fetch_en_i) begin
      nop_q   <= (state_q != IDLE);
      valid_q <= (state_q == IDLE);
    end
  end

  imem_array #(.A(A), .W(W)) u_array (
    .clk_i   (clk_i),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (load_data_i),
    .re_i    (re),
    .raddr_i (fetch_addr_i),
    .rdata_o (rdata)
  );

  assign load_ready_o  = (state_q == LOAD);
  assign busy_o        = (state_q != IDLE);
  assign load_done_o   = done_q;
  assign load_err_o    = err_q;
  assign instr_out_o   = nop_q ? NOP : rdata;
  assign instr_valid_o = valid_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader (A = 4, W = 9).
module tb_instr_mem_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_start, load_valid, fetch_en;
  logic [4:0] load_len;
  logic [8:0] load_data;
  logic [3:0] fetch_addr;
  logic       load_ready, load_done, load_err, busy, instr_valid;
  logic [8:0] instr_out;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  instr_mem_loader #(.A(4), .W(9)) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .load_start_i  (load_start),
    .load_len_i    (load_len),
    .load_valid_i  (load_valid),
    .load_data_i   (load_data),
    .load_ready_o  (load_ready),
    .load_done_o   (load_done),
    .load_err_o    (load_err),
    .busy_o        (busy),
    .fetch_en_i    (fetch_en),
    .fetch_addr_i  (fetch_addr),
    .instr_out_o   (instr_out),
    .instr_valid_o (instr_valid)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fetch_chk(input logic [3:0] a, input logic [8:0] exp, input string tag);
    fetch_en   = 1'b1;
    fetch_addr = a;
    step();
    chk(tag, instr_out, exp);
    chk({tag, "_vld"}, instr_valid, 1);
  endtask

  initial begin
    reset = 1'b1; load_start = 0; load_len = 0; load_valid = 0;
    load_data = 0; fetch_en = 0; fetch_addr = 0;

    // Reset state
    step(); step();
    chk("rst_instr", instr_out, 9'h000);
    chk("rst_valid", instr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", load_ready, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_err, 0);
    reset = 1'b0;

    // Full 16-word load, valid held high
    load_start = 1; load_len = 5'd16;
    step();
    load_start = 0; load_valid = 1;
    for (int i = 0; i < 16; i++) begin
      load_data = 9'h100 + 9'(i);
      chk("full_ready", load_ready, 1);
      chk("full_nodone", load_done, 0);
      step();
    end
    load_valid = 0;
    chk("full_done", load_done, 1);
    chk("full_busy_done", busy, 1);
    chk("full_ready_done", load_ready, 0);
    step();
    chk("full_done_once", load_done, 0);
    chk("full_idle", busy, 0);
    for (int a = 0; a < 16; a++)
      fetch_chk(4'(a), 9'h100 + 9'(a), "full_fetch");
    fetch_en = 0;

    // Bubbled 3-word load: valid 1,0,1,0,1
    load_start = 1; load_len = 5'd3;
    step();
    load_start = 0;
    begin
      logic [4:0] pat;
      int k;
      pat = 5'b10101;
      k = 0;
      for (int c = 0; c < 5; c++) begin
        load_valid = pat[c];
        load_data  = pat[c] ? 9'h1A0 + 9'(k) : 9'h1FF;
        if (pat[c]) k++;
        chk("bub_busy", busy, 1);
        chk("bub_nodone", load_done, 0);
        step();
      end
    end
    load_valid = 0;
    chk("bub_done", load_done, 1);
    step();
    chk("bub_idle", busy, 0);
    fetch_chk(4'd0, 9'h1A0, "bub_a0");
    fetch_chk(4'd1, 9'h1A1, "bub_a1");
    fetch_chk(4'd2, 9'h1A2, "bub_a2");
    fetch_chk(4'd3, 9'h103, "bub_a3_kept");
    fetch_en = 0;

    // Illegal lengths 0 and 17
    load_start = 1; load_len = 5'd0;
    step();
    load_start = 0;
    chk("err0_pulse", load_err, 1);
    chk("err0_busy", busy, 0);
    chk("err0_ready", load_ready, 0);
    step();
    chk("err0_clear", load_err, 0);
    load_start = 1; load_len = 5'd17;
    step();
    load_start = 0;
    chk("err17_pulse", load_err, 1);
    chk("err17_busy", busy, 0);
    step();
    chk("err17_clear", load_err, 0);
    chk("err17_idle", busy, 0);
    fetch_chk(4'd0, 9'h1A0, "err_mem0");
    fetch_chk(4'd3, 9'h103, "err_mem3");
    fetch_chk(4'd15, 9'h10F, "err_mem15");
    fetch_en = 0;

    // Fetch during LOAD gives NOP; fetch after DONE sees new data; stall holds
    load_start = 1; load_len = 5'd2;
    step();
    load_start = 0;
    fetch_en = 1; fetch_addr = 4'd5;
    step();
    chk("ld_fetch_nop", instr_out, 9'h000);
    chk("ld_fetch_vld", instr_valid, 0);
    load_valid = 1; load_data = 9'h0C0;
    step();
    load_data = 9'h0C1;
    step();
    load_valid = 0;
    chk("ld2_done", load_done, 1);
    step();
    chk("done_fetch_nop", instr_out, 9'h000);
    chk("done_fetch_vld", instr_valid, 0);
    fetch_chk(4'd0, 9'h0C0, "after_done_a0");
    fetch_chk(4'd5, 9'h105, "stall_a5");
    fetch_en = 0; fetch_addr = 4'd7;
    for (int s = 0; s < 3; s++) begin
      step();
      chk("stall_hold", instr_out, 9'h105);
      chk("stall_vld", instr_valid, 1);
    end

    // Same-cycle start + fetch: old data served, then reset mid-load
    load_start = 1; load_len = 5'd8; fetch_en = 1; fetch_addr = 4'd1;
    step();
    load_start = 0; fetch_en = 0;
    chk("same_cyc_old", instr_out, 9'h0C1);
    chk("same_cyc_busy", busy, 1);
    load_valid = 1;
    for (int i = 0; i < 4; i++) begin
      load_data = 9'h0E0 + 9'(i);
      step();
    end
    reset = 1; load_valid = 0;
    step();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", load_done, 0);
    chk("mid_rst_ready", load_ready, 0);
    chk("mid_rst_instr", instr_out, 9'h000);
    chk("mid_rst_vld", instr_valid, 0);
    reset = 0;
    step();
    chk("mid_rst_nodone", load_done, 0);
    for (int a = 0; a < 4; a++)
      fetch_chk(4'(a), 9'h0E0 + 9'(a), "mid_rst_new");
    for (int a = 4; a < 8; a++)
      fetch_chk(4'(a), 9'h100 + 9'(a), "mid_rst_old");
    fetch_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
